// File: rtl/mem_port_arbiter_if.sv
// Bundle of client and memory-side signals around the shared memory port.
// The arbiter takes the slave view; the clients and the memory take the master view.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 16
`endif

interface mem_port_arbiter_if #(
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) ();
  logic                   rd_req;
  logic [MADDR_WIDTH-1:0] rd_addr;
  logic                   rd_ack;
  logic [MDATA_WIDTH-1:0] rd_data;
  logic                   rd_err;

  logic                   wr_req;
  logic [MADDR_WIDTH-1:0] wr_addr;
  logic [MDATA_WIDTH-1:0] wr_data;
  logic                   wr_ack;
  logic                   wr_err;

  logic                   mem_read_enable;
  logic                   mem_write_enable;
  logic [MADDR_WIDTH-1:0] mem_addr;
  logic [MDATA_WIDTH-1:0] mem_write_data;
  logic [MDATA_WIDTH-1:0] mem_read_data;
  logic                   mem_read_ready;
  logic                   mem_write_ready;

  logic                   busy;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  mem_read_data, mem_read_ready, mem_write_ready,
    output rd_ack, rd_data, rd_err, wr_ack, wr_err,
    output mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
    output busy
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output mem_read_data, mem_read_ready, mem_write_ready,
    input  rd_ack, rd_data, rd_err, wr_ack, wr_err,
    input  mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving the single memory port to the read or write client,
// with registered address/data, ready handshake, timeout abort and one-cycle acks.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 16
`endif

module mem_port_arbiter #(
  parameter int MADDR_WIDTH    = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH    = `DEFAULT_MDATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic             clock,
  input logic             reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY, DONE} state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t                 state;
  logic [CNT_W-1:0]       timeout_count;
  logic                   last_served_write;
  logic                   timeout_hit;

  logic                   rd_ack_q;
  logic                   rd_err_q;
  logic [MDATA_WIDTH-1:0] rd_data_q;
  logic                   wr_ack_q;
  logic                   wr_err_q;
  logic                   read_enable_q;
  logic                   write_enable_q;
  logic [MADDR_WIDTH-1:0] addr_q;
  logic [MDATA_WIDTH-1:0] write_data_q;
  logic                   busy_q;

  // A zero TIMEOUT_CYCLES leaves the counter running but never aborts.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timeout_count == LAST_COUNT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      timeout_count     <= '0;
      last_served_write <= 1'b1;
      rd_ack_q          <= 1'b0;
      rd_err_q          <= 1'b0;
      rd_data_q         <= '0;
      wr_ack_q          <= 1'b0;
      wr_err_q          <= 1'b0;
      read_enable_q     <= 1'b0;
      write_enable_q    <= 1'b0;
      addr_q            <= '0;
      write_data_q      <= '0;
      busy_q            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // On a tie the read wins only if the write was served last.
          if (bus.rd_req && (!bus.wr_req || last_served_write)) begin
            state             <= RD_BUSY;
            read_enable_q     <= 1'b1;
            addr_q            <= bus.rd_addr;
            busy_q            <= 1'b1;
            timeout_count     <= '0;
            last_served_write <= 1'b0;
          end else if (bus.wr_req) begin
            state             <= WR_BUSY;
            write_enable_q    <= 1'b1;
            addr_q            <= bus.wr_addr;
            write_data_q      <= bus.wr_data;
            busy_q            <= 1'b1;
            timeout_count     <= '0;
            last_served_write <= 1'b1;
          end
        end

        RD_BUSY: begin
          // Ready takes priority over a timeout landing on the same edge.
          if (bus.mem_read_ready) begin
            state         <= DONE;
            read_enable_q <= 1'b0;
            rd_data_q     <= bus.mem_read_data;
            rd_ack_q      <= 1'b1;
            rd_err_q      <= 1'b0;
          end else if (timeout_hit) begin
            state         <= DONE;
            read_enable_q <= 1'b0;
            rd_data_q     <= '0;
            rd_ack_q      <= 1'b1;
            rd_err_q      <= 1'b1;
          end else begin
            timeout_count <= timeout_count + 1'b1;
          end
        end

        WR_BUSY: begin
          if (bus.mem_write_ready) begin
            state          <= DONE;
            write_enable_q <= 1'b0;
            wr_ack_q       <= 1'b1;
            wr_err_q       <= 1'b0;
          end else if (timeout_hit) begin
            state          <= DONE;
            write_enable_q <= 1'b0;
            wr_ack_q       <= 1'b1;
            wr_err_q       <= 1'b1;
          end else begin
            timeout_count <= timeout_count + 1'b1;
          end
        end

        DONE: begin
          state    <= IDLE;
          rd_ack_q <= 1'b0;
          rd_err_q <= 1'b0;
          wr_ack_q <= 1'b0;
          wr_err_q <= 1'b0;
          busy_q   <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_ack           = rd_ack_q;
  assign bus.rd_err           = rd_err_q;
  assign bus.rd_data          = rd_data_q;
  assign bus.wr_ack           = wr_ack_q;
  assign bus.wr_err           = wr_err_q;
  assign bus.mem_read_enable  = read_enable_q;
  assign bus.mem_write_enable = write_enable_q;
  assign bus.mem_addr         = addr_q;
  assign bus.mem_write_data   = write_data_q;
  assign bus.busy             = busy_q;

endmodule
